cmp_result_window_counter: RTL and testbench
============================================

Name: cmp_result_window_counter

Overview:
- Downstream stage of the 16-bit magnitude comparator.
- Consumes one gt/eq/lt flag triple per accepted sample.
- Counts the greater, equal and less outcomes over a window of WINDOW samples, or fewer if flushed early.
- Presents the window totals on a valid/ready result port, feeding statistics/threshold logic further down the datapath.

Parameters:
- WINDOW, 16: number of accepted samples per reporting window; legal range 1 to 2^CNT_W-1.
- CNT_W, 16: width of every count output; must satisfy 2^CNT_W > WINDOW, so counters never overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  flag triple valid this cycle.
- in_ready  output  1  block can accept a triple; a sample is accepted when in_valid and in_ready are both high.
- gt_in  input  1  comparator a>b flag.
- eq_in  input  1  comparator a==b flag.
- lt_in  input  1  comparator a<b flag.
- flush  input  1  close the current window early.
- out_valid  output  1  window result valid.
- out_ready  input  1  downstream accepts result.
- gt_cnt  output  CNT_W  gt outcomes in window.
- eq_cnt  output  CNT_W  eq outcomes in window.
- lt_cnt  output  CNT_W  lt outcomes in window.
- n_cnt  output  CNT_W  total samples accepted in window.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM.
  - gt_cnt, eq_cnt, lt_cnt and n_cnt are 0.
  - out_valid=0, in_ready=1.
  - Reset overrides everything, including mid-window and mid-REPORT. A pending result is discarded.
- All outputs are registered. in_ready is 1 exactly when state is ACCUM.
- State ACCUM:
  - On accept, n_cnt increments by 1.
  - Classification is priority encoded, gt > eq > lt:
    - gt_in=1: gt_cnt increments.
    - else eq_in=1: eq_cnt increments.
    - else lt_in=1: lt_cnt increments.
    - All flags 0: only n_cnt increments.
  - Transition to REPORT when the accepted sample makes n_cnt equal WINDOW.
  - flush=1 also moves to REPORT if either of these holds:
    - the sample count is already at least 1; or
    - a sample is accepted in the same cycle. That sample is counted first.
  - flush with zero samples and no accept: ignored; the block stays in ACCUM.
- Latency: out_valid goes high on the clock edge that accepts the last sample of the window. It is therefore visible in the cycle after the accept, with the final counts.
- State REPORT:
  - in_ready=0, out_valid=1.
  - All count outputs are held stable until the handshake.
  - flush and in_valid are ignored.
  - On out_valid and out_ready: all counts clear to 0, out_valid=0, and the state returns to ACCUM. in_ready=1 from the next cycle.
  - The block never reports and accepts in the same cycle, so there is one bubble cycle per window.
- Invariants:
  - gt_cnt + eq_cnt + lt_cnt <= n_cnt <= WINDOW.
  - Without the optional feature, equality holds whenever every sample has at least one flag set.
- WINDOW=1: every accepted sample produces a report.

Optional Feature:
- Macro: CMP_FLAG_CHECK_EN.
- Defined:
  - Adds output port flag_err (1 bit, reset 0).
  - A sample whose triple is not exactly one-hot (all zero, or two or more flags set) is counted only in n_cnt. It is not counted in any class counter.
  - Such a sample sets flag_err, which is sticky for the window.
  - flag_err is valid alongside out_valid and clears at the result handshake.
- Not defined:
  - No flag_err port.
  - Priority classification as described under Behaviour.

Test Plan (WINDOW=4, CNT_W=8):
- Reset, then 4 accepts with gt,eq,lt,gt and out_ready=1 -> out_valid high 1 cycle after the 4th accept; gt=2, eq=1, lt=1, n=4; in_ready returns 1 the cycle after the handshake.
- Full window of 4 eq samples, out_ready held 0 for 5 cycles -> out_valid and eq_cnt=4 stable for all 5 cycles, in_ready=0, and extra in_valid pulses are not counted.
- 2 lt samples, then flush with no in_valid -> report with lt=2, n=2. Separately, flush together with an accepted gt sample after 1 lt -> gt=1, lt=1, n=2.
- Flush asserted immediately after reset with no samples -> no report; the block stays in ACCUM with in_ready=1.
- Reset asserted after 3 samples (and again during REPORT) -> all counts 0, out_valid=0, in_ready=1 next cycle. The next window counts from 0.
- Triple gt=1, eq=1 plus 3 valid samples -> without the macro, gt counted (n=4). With CMP_FLAG_CHECK_EN, the bad sample is not classified, n=4, and flag_err=1 at report, then 0 after the handshake.

Source files
------------

// File: rtl/cmp_result_window_counter.sv
// rtl/cmp_result_window_counter.sv - windowed gt/eq/lt outcome counter with valid/ready result port
// Optional strict one-hot flag checking with a flag_err output: define CMP_FLAG_CHECK_EN.
module cmp_result_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
`ifdef CMP_FLAG_CHECK_EN
  output logic             flag_err,
`endif
  output logic [CNT_W-1:0] n_cnt
);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t state;
  logic   accept;
  logic   last_sample;
  logic   close_window;
  logic   one_hot;

  // in_ready is a registered copy of (state == ACCUM), so it can gate accept directly.
  always_comb begin
    accept       = 1'b0;
    last_sample  = 1'b0;
    close_window = 1'b0;
    one_hot      = 1'b0;
    accept       = in_valid && in_ready;
    last_sample  = accept && (n_cnt == CNT_W'(WINDOW - 1));
    close_window = last_sample || (flush && ((n_cnt != '0) || accept));
    one_hot      = (gt_in ^ eq_in ^ lt_in) && !(gt_in && eq_in && lt_in);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gt_cnt    <= '0;
      eq_cnt    <= '0;
      lt_cnt    <= '0;
      n_cnt     <= '0;
`ifdef CMP_FLAG_CHECK_EN
      flag_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            n_cnt <= n_cnt + CNT_W'(1);
`ifdef CMP_FLAG_CHECK_EN
            if (!one_hot) begin
              flag_err <= 1'b1;
            end else if (gt_in) begin
              gt_cnt <= gt_cnt + CNT_W'(1);
            end else if (eq_in) begin
              eq_cnt <= eq_cnt + CNT_W'(1);
            end else begin
              lt_cnt <= lt_cnt + CNT_W'(1);
            end
`else
            if (gt_in) begin
              gt_cnt <= gt_cnt + CNT_W'(1);
            end else if (eq_in) begin
              eq_cnt <= eq_cnt + CNT_W'(1);
            end else if (lt_in) begin
              lt_cnt <= lt_cnt + CNT_W'(1);
            end
`endif
          end
          if (close_window) begin
            state     <= REPORT;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        REPORT: begin
          // Counts hold until the result is taken; new samples wait one bubble cycle.
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            lt_cnt    <= '0;
            n_cnt     <= '0;
`ifdef CMP_FLAG_CHECK_EN
            flag_err  <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef CMP_FLAG_CHECK_EN
  logic unused_one_hot;
  assign unused_one_hot = one_hot;
`endif

endmodule

// File: tb/tb_cmp_result_window_counter.sv
// tb/tb_cmp_result_window_counter.sv - scoreboard bench for cmp_result_window_counter
module tb_cmp_result_window_counter;
  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, gt_in, eq_in, lt_in, flush, out_valid, out_ready;
  logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, n_cnt;
`ifdef CMP_FLAG_CHECK_EN
  logic flag_err;
`endif

  always #5 clk = ~clk;

  cmp_result_window_counter #(.WINDOW(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
`ifdef CMP_FLAG_CHECK_EN
    .flag_err(flag_err),
`endif
    .n_cnt(n_cnt)
  );

  typedef struct {int gt; int eq; int lt; int n; bit err;} exp_t;
  exp_t       exp_q[$];
  logic [2:0] samples[$];
  bit         pending;
  bit         known;
  int         checks;
  int         errors;
  int         reports;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Window totals derived from the list of accepted {gt,eq,lt} triples.
  function automatic exp_t summarize();
    exp_t e;
    e = '{0, 0, 0, 0, 1'b0};
    foreach (samples[i]) begin
      e.n++;
`ifdef CMP_FLAG_CHECK_EN
      if ($countones(samples[i]) != 1) e.err = 1'b1;
      else if (samples[i][2]) e.gt++;
      else if (samples[i][1]) e.eq++;
      else e.lt++;
`else
      if (samples[i][2]) e.gt++;
      else if (samples[i][1]) e.eq++;
      else if (samples[i][0]) e.lt++;
`endif
    end
    return e;
  endfunction

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input bit iv, input bit g, input bit e, input bit l,
                      input bit fl, input bit ordy, input bit rs);
    if (known) begin
      check("in_ready", int'(in_ready), int'(!pending));
      check("out_valid", int'(out_valid), int'(pending));
      if (!pending) check("n_cnt_accum", int'(n_cnt), samples.size());
    end
    in_valid = iv; gt_in = g; eq_in = e; lt_in = l;
    flush = fl; out_ready = ordy; rst_n = !rs;
    if (rs) begin
      pending = 1'b0;
      samples.delete();
      exp_q.delete();
      known = 1'b1;
    end else if (known) begin
      if (pending) begin
        if (ordy) pending = 1'b0;
      end else begin
        if (iv) samples.push_back({g, e, l});
        if ((iv && samples.size() == W) || (fl && samples.size() > 0)) begin
          exp_q.push_back(summarize());
          samples.delete();
          pending = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares on handshake, and checks hold stability while stalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && known && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_report", 1, 0);
      end else begin
        check("gt_cnt", int'(gt_cnt), exp_q[0].gt);
        check("eq_cnt", int'(eq_cnt), exp_q[0].eq);
        check("lt_cnt", int'(lt_cnt), exp_q[0].lt);
        check("n_cnt", int'(n_cnt), exp_q[0].n);
`ifdef CMP_FLAG_CHECK_EN
        check("flag_err", int'(flag_err), int'(exp_q[0].err));
`endif
        if (out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          reports++;
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; reports = 0; pending = 0; known = 0;
    in_valid = 0; gt_in = 0; eq_in = 0; lt_in = 0; flush = 0; out_ready = 0; rst_n = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset_n_cnt", int'(n_cnt), 0);
    check("reset_gt_cnt", int'(gt_cnt), 0);
    // Flush with no samples straight after reset is ignored.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // gt, eq, lt, gt with out_ready high.
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Four eq samples, then a 5-cycle stall with extra in_valid pulses.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Two lt then a bare flush; then lt followed by flush with an accepted gt.
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Reset mid-window and again mid-report.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    // Multi-hot triple followed by three clean samples.
    step(1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, f[2], f[1], f[0],
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("reports_seen", int'(reports > 20), 1);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
